// File: rtl/tl_rx_err_msg_sender.sv
// tl_rx_err_msg_sender: pops error FIFO entries and offers the error message,
// plus an optional Unsupported Request completion, to the TX arbiter.
module tl_rx_err_msg_sender #(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [127:0]         fifo_tlp_msg,
  input  logic                 fifo_ur_cpl_valid,
  output logic                 fifo_msg_trans_en,
  output logic                 fifo_read_ptr_incr,
  input  logic [15:0]          completer_id,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [127:0]         tx_hdr,
  output logic                 tx_is_cpl,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] msg_cnt,
  output logic [CNT_WIDTH-1:0] cpl_cnt
);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, MSG, CPL, GAP} state_t;
  localparam state_t AFTER = GAP_CYCLES > 0 ? GAP : IDLE;
  state_t state, state_n;
  logic [127:0] msg_q;
  logic cpl_q, pop, hs;
  logic [GW-1:0] gap_cnt;
  assign pop = state == IDLE && !fifo_empty;
  assign fifo_msg_trans_en = pop;
  assign fifo_read_ptr_incr = pop;
  assign hs = tx_valid && tx_ready;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    tx_valid = 1'b0;
    tx_is_cpl = 1'b0;
    tx_hdr = '0;
    case (state)
      IDLE: state_n = pop ? MSG : IDLE;
      MSG: begin
        tx_valid = 1'b1;
        tx_hdr = msg_q;
        if (tx_ready) state_n = cpl_q ? CPL : AFTER;
      end
      CPL: begin
        tx_valid = 1'b1;
        tx_is_cpl = 1'b1;
        tx_hdr = {32'h0A00_0000, completer_id, 3'b001, 1'b0, 12'd0,
                  msg_q[95:80], msg_q[79:72], 8'h00, 32'h0};
        if (tx_ready) state_n = AFTER;
      end
      default: state_n = gap_cnt == '0 ? IDLE : GAP;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      msg_q <= '0;
      cpl_q <= 1'b0;
      gap_cnt <= '0;
      msg_cnt <= '0;
      cpl_cnt <= '0;
    end else begin
      state <= state_n;
      if (pop) begin
        msg_q <= fifo_tlp_msg;
        cpl_q <= fifo_ur_cpl_valid;
      end
      // load on GAP entry, count down while staying
      if (state_n == GAP) gap_cnt <= state == GAP ? gap_cnt - 1'b1 : GAP_LOAD;
      if (hs && !tx_is_cpl && msg_cnt != '1) msg_cnt <= msg_cnt + 1'b1;
      if (hs && tx_is_cpl && cpl_cnt != '1) cpl_cnt <= cpl_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_tl_rx_err_msg_sender.sv
// tb_tl_rx_err_msg_sender: randomized and directed checks of the error report
// sender against a queue-based model of FIFO entries and pending report beats.
`timescale 1ns/1ps
module tb_tl_rx_err_msg_sender;
  localparam int G = 2;
  logic clk, rst;
  logic fifo_empty, fifo_ur_cpl_valid, fifo_msg_trans_en, fifo_read_ptr_incr;
  logic [127:0] fifo_tlp_msg, tx_hdr;
  logic [15:0] completer_id;
  logic tx_valid, tx_ready, tx_is_cpl, busy;
  logic [7:0] msg_cnt, cpl_cnt;
  logic fifo_empty1, en1, pop1, tx_valid1, tx_is_cpl1, busy1;
  logic [127:0] fifo_tlp_msg1, tx_hdr1;
  logic [7:0] msg_cnt1, cpl_cnt1;
  int total = 0, bad = 0, cyc = 0, gap = 0;
  logic [7:0] mc = 0, cc = 0;
  logic [128:0] fq[$];
  logic [127:0] fq1[$];
  logic [127:0] bh[$];
  bit bc[$];
  int pops1[$];

  tl_rx_err_msg_sender #(.GAP_CYCLES(G), .CNT_WIDTH(8)) u0 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_tlp_msg(fifo_tlp_msg),
    .fifo_ur_cpl_valid(fifo_ur_cpl_valid), .fifo_msg_trans_en(fifo_msg_trans_en),
    .fifo_read_ptr_incr(fifo_read_ptr_incr), .completer_id(completer_id),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_hdr(tx_hdr), .tx_is_cpl(tx_is_cpl),
    .busy(busy), .msg_cnt(msg_cnt), .cpl_cnt(cpl_cnt));

  tl_rx_err_msg_sender #(.GAP_CYCLES(0), .CNT_WIDTH(8)) u1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty1), .fifo_tlp_msg(fifo_tlp_msg1),
    .fifo_ur_cpl_valid(1'b0), .fifo_msg_trans_en(en1),
    .fifo_read_ptr_incr(pop1), .completer_id(completer_id),
    .tx_valid(tx_valid1), .tx_ready(1'b1), .tx_hdr(tx_hdr1), .tx_is_cpl(tx_is_cpl1),
    .busy(busy1), .msg_cnt(msg_cnt1), .cpl_cnt(cpl_cnt1));

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] cpl_of(input logic [127:0] m);
    return {32'h0A00_0000, completer_id, 16'h2000, m[95:72], 8'h00, 32'h0};
  endfunction

  function automatic logic [7:0] sat(input logic [7:0] v);
    return v == 8'hFF ? v : v + 8'd1;
  endfunction

  function automatic bit idle_m();
    return bh.size() == 0 && gap == 0;
  endfunction

  task automatic drive();
    logic [128:0] e;
    e = fq.size() > 0 ? fq[0] : '0;
    fifo_empty = fq.size() == 0;
    fifo_tlp_msg = e[127:0];
    fifo_ur_cpl_valid = e[128];
    fifo_empty1 = fq1.size() == 0;
    fifo_tlp_msg1 = fq1.size() > 0 ? fq1[0] : '0;
  endtask

  task automatic push(input bit u, input logic [127:0] m);
    fq.push_back({u, m});
  endtask

  task automatic push_rand(input bit u);
    push(u, {$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic tick();
    logic p, p1, h;
    logic [128:0] e;
    drive();
    #1;
    p = idle_m() && fq.size() > 0;
    chk("pop", fifo_read_ptr_incr, p);
    chk("trans_en", fifo_msg_trans_en, p);
    chk("busy", busy, !idle_m());
    chk("tx_valid", tx_valid, bh.size() > 0);
    chk("tx_hdr", tx_hdr, bh.size() > 0 ? bh[0] : 128'h0);
    chk("tx_is_cpl", tx_is_cpl, bh.size() > 0 ? bc[0] : 1'b0);
    chk("msg_cnt", msg_cnt, mc);
    chk("cpl_cnt", cpl_cnt, cc);
    h = bh.size() > 0 && tx_ready;
    p1 = pop1;
    @(posedge clk);
    if (p) begin
      e = fq.pop_front();
      bh.push_back(e[127:0]);
      bc.push_back(1'b0);
      if (e[128]) begin
        bh.push_back(cpl_of(e[127:0]));
        bc.push_back(1'b1);
      end
    end else if (h) begin
      if (bc[0]) cc = sat(cc);
      else mc = sat(mc);
      bh.delete(0);
      bc.delete(0);
      if (bh.size() == 0) gap = G;
    end else if (gap > 0) gap--;
    if (p1) begin
      fq1.delete(0);
      pops1.push_back(cyc);
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst = 0;
    tx_ready = 0;
    completer_id = 16'h0200;
    drive();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_hdr", tx_hdr, 128'h0);
    chk("rst_msg_cnt", msg_cnt, 8'h0);
    chk("rst_cpl_cnt", cpl_cnt, 8'h0);
    rst = 1;
    @(negedge clk);
    // single message, no completion
    tx_ready = 1;
    push(1'b0, {32'h3000_0000, 16'h1234, 8'h05, 8'h31, 64'h0});
    repeat (6) tick();
    chk("single_msg_cnt", msg_cnt, 8'd1);
    chk("single_cpl_cnt", cpl_cnt, 8'd0);
    // stalled TX with another entry waiting
    tx_ready = 0;
    push_rand(1'b0);
    push_rand(1'b1);
    repeat (12) tick();
    tx_ready = 1;
    repeat (14) tick();
    // GAP_CYCLES=0 instance: pops two cycles apart
    repeat (3) fq1.push_back({$urandom, $urandom, $urandom, $urandom});
    repeat (10) tick();
    chk("b2b_pops", pops1.size(), 3);
    if (pops1.size() == 3) begin
      chk("b2b_space0", pops1[1] - pops1[0], 2);
      chk("b2b_space1", pops1[2] - pops1[1], 2);
    end
    chk("b2b_msg_cnt", msg_cnt1, 8'd3);
    // random traffic
    completer_id = 16'($urandom);
    repeat (300) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 4) push_rand(1'($urandom_range(0, 1)));
      tx_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    tx_ready = 1;
    repeat (40) tick();
    // saturate msg_cnt
    repeat (1100) begin
      if (fq.size() < 2) push_rand(1'b0);
      tick();
    end
    repeat (8) tick();
    chk("sat_msg_cnt", msg_cnt, 8'hFF);
    // reset while a completion is being offered
    completer_id = 16'h0200;
    push(1'b1, {32'h7400_0000, 16'h0100, 8'h2A, 8'h31, 64'h0});
    for (int i = 0; i < 10 && !(bh.size() == 1 && bc[0]); i++) tick();
    tx_ready = 0;
    repeat (2) tick();
    #1;
    chk("cpl_flag", tx_is_cpl, 1'b1);
    chk("cpl_dw1", tx_hdr[95:64], 32'h0200_2000);
    chk("cpl_dw2", tx_hdr[63:32], 32'h0100_2A00);
    #1 rst = 0;
    #1;
    chk("arst_valid", tx_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_msg_cnt", msg_cnt, 8'h0);
    chk("arst_cpl_cnt", cpl_cnt, 8'h0);
    bh.delete();
    bc.delete();
    gap = 0;
    mc = 0;
    cc = 0;
    @(negedge clk);
    repeat (2) tick();
    rst = 1;
    tx_ready = 1;
    push(1'b0, {32'h3000_0000, 16'h0300, 8'h11, 8'h30, 64'h0});
    repeat (6) tick();
    chk("post_rst_msg_cnt", msg_cnt, 8'd1);
    chk("post_rst_cpl_cnt", cpl_cnt, 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tl_rx_err_msg_sender.md
TL_RX_ERR_MSG_SENDER -- requirements
Module: tl_rx_err_msg_sender

Interface
REQ-001 Parameter: GAP_CYCLES, default 2, idle cycles forced between consecutive reports (0 = none).
REQ-002 Parameter: CNT_WIDTH, default 8, width of the report counters.
REQ-003 clk  input  1  clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 fifo_empty  input  1  error FIFO empty flag.
REQ-006 fifo_tlp_msg  input  128  error message header {DW0,DW1,DW2,DW3}; DW1 = fifo_tlp_msg[95:64] = {req_id[95:80], tag[79:72], msg_code[71:64]}.
REQ-007 fifo_ur_cpl_valid  input  1  entry also requires an Unsupported Request completion.
REQ-008 fifo_msg_trans_en  output  1  enables the FIFO header and completion-flag outputs.
REQ-009 fifo_read_ptr_incr  output  1  single-cycle pop of the FIFO entry.
REQ-010 completer_id  input  16  local bus/device/function used in the completion header.
REQ-011 tx_valid  output  1  header offered to the TX arbiter.
REQ-012 tx_ready  input  1  TX arbiter accepts the header.
REQ-013 tx_hdr  output  128  TLP header, 4 DW.
REQ-014 tx_is_cpl  output  1  0 = error message, 1 = UR completion.
REQ-015 busy  output  1  high whenever the state is not IDLE.
REQ-016 msg_cnt  output  CNT_WIDTH  count of error messages accepted by TX, saturating.
REQ-017 cpl_cnt  output  CNT_WIDTH  count of UR completions accepted by TX, saturating.

Function
REQ-018 The FSM SHALL have states IDLE, MSG, CPL and GAP, and SHALL reset to IDLE.
REQ-019 fifo_msg_trans_en and fifo_read_ptr_incr SHALL both equal (state==IDLE && !fifo_empty), combinationally.
REQ-020 On a clock edge where fifo_read_ptr_incr is high, the block SHALL latch fifo_tlp_msg into msg_q and fifo_ur_cpl_valid into cpl_q, and SHALL go to MSG; this edge is both capture and pop.
REQ-021 In MSG: tx_valid=1, tx_is_cpl=0, tx_hdr=msg_q.
- On tx_ready, go to CPL if cpl_q=1.
- Otherwise go to GAP if GAP_CYCLES>0, else to IDLE.
REQ-022 In CPL: tx_valid=1, tx_is_cpl=1, tx_hdr={32'h0A00_0000, {completer_id, 3'b001, 1'b0, 12'd0}, {msg_q[95:80], msg_q[79:72], 8'h00}, 32'h0}; on tx_ready, go to GAP if GAP_CYCLES>0, else to IDLE.
REQ-023 tx_hdr and tx_is_cpl SHALL stay stable while tx_valid=1 and tx_ready=0; there is no timeout, and the block waits indefinitely.
REQ-024 In IDLE and GAP: tx_valid=0, tx_is_cpl=0, tx_hdr=0.
REQ-025 GAP SHALL load a down-counter with GAP_CYCLES-1 on entry and go to IDLE in the cycle the counter reads 0, giving exactly GAP_CYCLES cycles in GAP.
REQ-026 msg_cnt SHALL increment on every MSG handshake (tx_valid && tx_ready), and cpl_cnt on every CPL handshake; both SHALL hold at 2^CNT_WIDTH-1 once saturated.
REQ-027 No pop SHALL occur outside IDLE; a FIFO that becomes non-empty during MSG, CPL or GAP is served on the first IDLE cycle.
REQ-028 Back-to-back entries with GAP_CYCLES=0 SHALL sustain one report per 2 cycles (IDLE, MSG) when tx_ready is held high.
REQ-029 fifo_empty high in IDLE SHALL keep the block in IDLE with both FIFO controls low.

Reset
REQ-030 On rst low, asynchronously:
- state=IDLE;
- msg_q=0, cpl_q=0, gap counter=0;
- msg_cnt=0, cpl_cnt=0;
- tx_valid=0, tx_is_cpl=0, tx_hdr=0, busy=0.
REQ-031 An entry already popped when reset asserts SHALL be discarded; no partial report SHALL be offered after reset is released.

Verification
REQ-032 Single entry, msg_code 8'h31, cpl flag 0, tx_ready=1, GAP_CYCLES=2 -> one pop, one MSG beat with tx_hdr[127:96]=32'h3000_0000, then 2 GAP cycles, msg_cnt=1, cpl_cnt=0.
REQ-033 Entry with req_id 16'h0100, tag 8'h2A, cpl flag 1, completer_id 16'h0200 -> MSG beat, then CPL beat with DW1=32'h0200_2000 and DW2=32'h0100_2A00, cpl_cnt=1.
REQ-034 tx_ready held low 10 cycles in MSG -> tx_valid stays 1, tx_hdr unchanged, no second pop, no counter change.
REQ-035 Three entries queued, GAP_CYCLES=0, tx_ready=1 -> pops exactly 2 cycles apart, msg_cnt=3.
REQ-036 rst asserted during CPL -> tx_valid drops immediately, counters read 0, and after release the next non-empty FIFO entry is served from IDLE.
REQ-037 2^CNT_WIDTH+1 messages sent -> msg_cnt saturates at 8'hFF.
